// File: rtl/cv32e41s_wfi_sleep_ctrl_if.sv
// -----------------------------------------------------------------------------
// cv32e41s_wfi_sleep_ctrl_if
//
// Purpose: bundles the handshake between the core pipeline / controller and
// the WFI sleep sequencer, so both sides connect through one port.
//
// Parameters:
//   NUM_IRQ           width of the wake-source interrupt vector
//
// Signals (direction as seen by the sequencer, modport slave):
//   wfi_i             in   single-cycle pulse, a WFI is retiring in WB
//   debug_mode_i      in   core is in debug mode
//   debug_req_i       in   external debug request
//   irq_wu_i          in   pending interrupts ANDed with MIE
//   if_busy_i         in   fetch stage has outstanding transactions
//   lsu_busy_i        in   LSU has outstanding transactions
//   ctrl_busy_o       out  core requires a clock
//   wake_from_sleep_o out  force-enable the core clock
//   sleeping_o        out  sequencer is in SLEEP
//   resume_o          out  one-cycle pulse on the first clocked cycle after wake
//   sleep_cycles_o    out  length of the last sleep period
//
// The master modport is the core/controller side that drives the status
// inputs and consumes the clock-control outputs.
// -----------------------------------------------------------------------------
interface cv32e41s_wfi_sleep_ctrl_if #(
  parameter int unsigned NUM_IRQ = 32
);

  logic               wfi_i;
  logic               debug_mode_i;
  logic               debug_req_i;
  logic [NUM_IRQ-1:0] irq_wu_i;
  logic               if_busy_i;
  logic               lsu_busy_i;

  logic               ctrl_busy_o;
  logic               wake_from_sleep_o;
  logic               sleeping_o;
  logic               resume_o;
  logic [31:0]        sleep_cycles_o;

  // Core / controller side
  modport master (
    output wfi_i,
    output debug_mode_i,
    output debug_req_i,
    output irq_wu_i,
    output if_busy_i,
    output lsu_busy_i,
    input  ctrl_busy_o,
    input  wake_from_sleep_o,
    input  sleeping_o,
    input  resume_o,
    input  sleep_cycles_o
  );

  // Sleep sequencer side
  modport slave (
    input  wfi_i,
    input  debug_mode_i,
    input  debug_req_i,
    input  irq_wu_i,
    input  if_busy_i,
    input  lsu_busy_i,
    output ctrl_busy_o,
    output wake_from_sleep_o,
    output sleeping_o,
    output resume_o,
    output sleep_cycles_o
  );

endinterface

// File: rtl/cv32e41s_wfi_sleep_ctrl.sv
// -----------------------------------------------------------------------------
// cv32e41s_wfi_sleep_ctrl
//
// Purpose: WFI sleep sequencer running on the free-running clock, sitting
// directly upstream of the sleep unit. A retiring WFI becomes a sleep request;
// the sequencer waits for fetch and LSU to drain, then drops ctrl_busy so the
// core clock can be gated, and raises wake_from_sleep when an enabled
// interrupt or a debug request shows up.
//
// Parameters:
//   NUM_IRQ        width of the wake-source interrupt vector (must match bus)
//
// Ports:
//   clk_ungated_i  in   free-running clock (never the gated core clock)
//   rst_n          in   asynchronous active-low reset
//   bus            slave modport of cv32e41s_wfi_sleep_ctrl_if carrying the
//                  WFI/debug/irq/busy inputs and the ctrl_busy,
//                  wake_from_sleep, sleeping, resume and sleep_cycles outputs
//
// Configuration macro:
//   CV32E41S_SLEEP_CNT_EN  when defined, a saturating 32-bit counter measures
//                          the length of the last sleep period and drives
//                          sleep_cycles_o; when undefined sleep_cycles_o is 0
//                          and no counter flops exist.
// -----------------------------------------------------------------------------
module cv32e41s_wfi_sleep_ctrl #(
  parameter int unsigned NUM_IRQ = 32
) (
  input  logic                          clk_ungated_i,
  input  logic                          rst_n,
  cv32e41s_wfi_sleep_ctrl_if.slave      bus
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] SLEEP = 2'd2;
  localparam logic [1:0] WAKE  = 2'd3;

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [NUM_IRQ-1:0] irq_wu;
  logic               wake_src;
  logic               drain_idle;

  // Any enabled interrupt or a debug request is a reason to wake up.
  // mstatus.MIE deliberately plays no part: a masked-but-enabled interrupt
  // still ends the WFI.
  assign irq_wu     = bus.irq_wu_i;
  assign wake_src   = (|irq_wu) || bus.debug_req_i;
  assign drain_idle = !bus.if_busy_i && !bus.lsu_busy_i;

  // Next-state logic. A WFI only starts a sleep from RUN, outside debug mode
  // and with no wake source already pending; otherwise it retires as a NOP.
  // In DRAIN a wake source wins over the drain completing, so we never enter
  // SLEEP with a wake reason already present.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (bus.wfi_i && !bus.debug_mode_i && !wake_src) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wake_src) begin
          state_d = RUN;
        end else if (drain_idle) begin
          state_d = SLEEP;
        end
      end
      SLEEP: begin
        if (wake_src) begin
          state_d = WAKE;
        end
      end
      WAKE: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ctrl_busy, sleeping and resume come straight from the state register so
  // the clock-gate enable has no combinational path from the core inputs.
  assign bus.ctrl_busy_o = (state_q != SLEEP);
  assign bus.sleeping_o  = (state_q == SLEEP);
  assign bus.resume_o    = (state_q == WAKE);

  // wake_from_sleep must open the clock in the very cycle a wake source is
  // seen in SLEEP. It stays high through WAKE because the sleep unit keeps a
  // registered copy of ctrl_busy that still reads 0 in that cycle.
  assign bus.wake_from_sleep_o = ((state_q == SLEEP) && wake_src) || (state_q == WAKE);

`ifdef CV32E41S_SLEEP_CNT_EN
  logic [31:0] sleep_cnt_q;
  logic        enter_sleep;

  assign enter_sleep = (state_q == DRAIN) && (state_d == SLEEP);

  // Counts every cycle spent in SLEEP, including the one in which the wake
  // source arrives, so the value seen from WAKE onward equals the number of
  // SLEEP cycles. Cleared on entry, held everywhere else, saturating.
  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      sleep_cnt_q <= '0;
    end else if (enter_sleep) begin
      sleep_cnt_q <= '0;
    end else if ((state_q == SLEEP) && (sleep_cnt_q != 32'hFFFF_FFFF)) begin
      sleep_cnt_q <= sleep_cnt_q + 32'd1;
    end
  end

  assign bus.sleep_cycles_o = sleep_cnt_q;
`else
  assign bus.sleep_cycles_o = '0;
`endif

endmodule
